// File: rtl/control_fsm_unit.sv
// control_fsm_unit: multi-cycle instruction sequencer driving ALU, accumulator and output register
module control_fsm_unit #(
  parameter int INSTR_W        = 16,
  parameter int OP_SEL_W       = 3,
  parameter int IDX_W          = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_valid_i,
  input  logic [INSTR_W-1:0]  instr_i,
  output logic                instr_ready_o,
  input  logic                alu_done_i,
  input  logic                resume_i,
  output logic                sub_o,
  output logic [OP_SEL_W-1:0] op_select_o,
  output logic                alu_start_o,
  output logic                acc_we_o,
  output logic                write_enable_o,
  output logic [IDX_W-1:0]    output_index_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic                illegal_op_o,
  output logic                timeout_err_o,
  output logic [CNT_W-1:0]    instr_count_o
);
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WAIT, S_OUT, S_HALT} state_e;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;
  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                illegal_q, illegal_d, timeout_q, timeout_d, retire;
  logic [3:0]          opc, nopc;
  logic                ready_q, ready_d, sub_q, sub_d, start_q, start_d, acc_q, acc_d;
  logic                we_q, we_d, halted_q, halted_d, exec_d, alu_d, md_d;
  logic [OP_SEL_W-1:0] op_q, op_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                unused_instr;
  assign opc  = instr_q[INSTR_W-1 -: 4];
  assign nopc = instr_d[INSTR_W-1 -: 4];
  assign unused_instr = ^instr_q;
  // next state, latched instruction, timeout counter, sticky flags and retire count
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    tmo_d     = tmo_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: if (instr_valid_i) begin
        instr_d = instr_i;
        state_d = S_EXEC;
      end
      S_EXEC: case (opc)
        OP_MUL, OP_DIV: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        OP_OUT: state_d = S_OUT;
        OP_HLT: begin
          retire  = 1'b1;
          state_d = S_HALT;
        end
        OP_ADD, OP_SUB, OP_NOP: begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          illegal_d = 1'b1;
          retire    = 1'b1;
          state_d   = S_IDLE;
        end
      endcase
      S_WAIT: if (alu_done_i) begin
        retire  = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_OUT: begin
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: if (resume_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    count_d = count_q + CNT_W'(retire);
  end
  // decode the outputs for the state being entered so they can be registered
  always_comb begin
    exec_d   = state_d == S_EXEC;
    alu_d    = nopc == OP_ADD || nopc == OP_SUB;
    md_d     = nopc == OP_MUL || nopc == OP_DIV;
    ready_d  = state_d == S_IDLE;
    halted_d = state_d == S_HALT;
    op_d     = ((exec_d && (alu_d || md_d)) || state_d == S_WAIT) ? OP_SEL_W'(nopc[2:0]) : '0;
    sub_d    = exec_d && nopc == OP_SUB;
    acc_d    = exec_d && alu_d;
    start_d  = exec_d && md_d;
    we_d     = state_d == S_OUT;
    idx_d    = we_d ? instr_d[IDX_W-1:0] : '0;
  end
  // single state register holding FSM state, datapath state and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      tmo_q     <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b1;
      halted_q  <= 1'b0;
      op_q      <= '0;
      sub_q     <= 1'b0;
      acc_q     <= 1'b0;
      start_q   <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      tmo_q     <= tmo_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
      halted_q  <= halted_d;
      op_q      <= op_d;
      sub_q     <= sub_d;
      acc_q     <= acc_d;
      start_q   <= start_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
    end
  end
  assign instr_ready_o  = ready_q;
  assign busy_o         = !ready_q;
  assign halted_o       = halted_q;
  assign op_select_o    = op_q;
  assign sub_o          = sub_q;
  assign alu_start_o    = start_q;
  assign acc_we_o       = acc_q || (state_q == S_WAIT && alu_done_i);
  assign write_enable_o = we_q;
  assign output_index_o = idx_q;
  assign illegal_op_o   = illegal_q;
  assign timeout_err_o  = timeout_q;
  assign instr_count_o  = count_q;
endmodule
